// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: control FSM for the iterative multiply/divide unit.
// Sequences operand load, per-cycle datapath steps driven by the shared
// step counter, divide-by-zero early exit and the result_ready pulse.
// Optional build macro MULTDIV_SEQ_ABORT_EN adds an abort input that
// cancels an operation in LOAD or RUN.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for ctrl_mult / ctrl_div
//   LOAD  | load operands, clear step counter, check divisor == 0
//   RUN   | one datapath step per cycle until the last step count
//   DONE  | result_ready pulse; a new start may be accepted here
module multdiv_sequencer #(
  parameter int CNT_W      = 6,
  parameter int MULT_STEPS = 16,
  parameter int DIV_STEPS  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             div_zero,
  input  logic [CNT_W-1:0] count_in,
`ifdef MULTDIV_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             load,
  output logic             step_en,
  output logic             op_is_div,
  output logic             busy,
  output logic             result_ready,
  output logic             exception
);

  // Last-step compare values; N = 2^CNT_W truncates to all-ones.
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state_q, state_d;
  logic   op_is_div_q, op_is_div_d;
  logic   exc_q, exc_d;
  logic   abort_req;
  logic   last_step;

`ifdef MULTDIV_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_step = (count_in == (op_is_div_q ? DIV_LAST : MULT_LAST));

  // Reset forces the held flags low even before the registers clear.
  assign op_is_div = op_is_div_q & ~reset;
  assign exception = exc_q & ~reset;

  // State and operation/exception registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_is_div_q <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_is_div_q <= op_is_div_d;
      exc_q       <= exc_d;
    end
  end

  // Next-state and strobe decode; reset overrides strobes and clears the counter.
  always_comb begin
    state_d      = state_q;
    op_is_div_d  = op_is_div_q;
    exc_d        = exc_q;
    cnt_en       = 1'b0;
    cnt_clr      = 1'b0;
    load         = 1'b0;
    step_en      = 1'b0;
    busy         = 1'b0;
    result_ready = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        result_ready = (state_q == DONE);
        if (ctrl_mult || ctrl_div) begin
          state_d     = LOAD;
          op_is_div_d = ctrl_div & ~ctrl_mult;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        load    = 1'b1;
        cnt_clr = 1'b1;
        busy    = 1'b1;
        if (abort_req) begin
          state_d = IDLE;
          exc_d   = 1'b0;
        end else if (op_is_div_q && div_zero) begin
          state_d = DONE;
          exc_d   = 1'b1;
        end else begin
          state_d = RUN;
          exc_d   = 1'b0;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort_req) begin
          // Cancelled step: clear the counter instead of advancing it.
          cnt_clr = 1'b1;
          state_d = IDLE;
          exc_d   = 1'b0;
        end else begin
          step_en = 1'b1;
          cnt_en  = 1'b1;
          if (last_step) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      cnt_en       = 1'b0;
      load         = 1'b0;
      step_en      = 1'b0;
      busy         = 1'b0;
      result_ready = 1'b0;
      cnt_clr      = 1'b1;
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: table of single operations
// with hand-computed latencies plus directed multi-cycle sequences.
module tb_multdiv_sequencer;

  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             ctrl_mult, ctrl_div, div_zero;
  logic [CNT_W-1:0] count_in;
  logic             abort;
  logic             cnt_en, cnt_clr, load, step_en, op_is_div, busy, result_ready, exception;

  int nerr   = 0;
  int nchecks = 0;

  multdiv_sequencer #(.CNT_W(CNT_W), .MULT_STEPS(16), .DIV_STEPS(32)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_mult(ctrl_mult),
    .ctrl_div(ctrl_div),
    .div_zero(div_zero),
    .count_in(count_in),
`ifdef MULTDIV_SEQ_ABORT_EN
    .abort(abort),
`endif
    .cnt_en(cnt_en),
    .cnt_clr(cnt_clr),
    .load(load),
    .step_en(step_en),
    .op_is_div(op_is_div),
    .busy(busy),
    .result_ready(result_ready),
    .exception(exception)
  );

  always #5 clock = ~clock;

  // Shared step counter the sequencer controls.
  always @(posedge clock) begin
    if (cnt_clr)     count_in <= '0;
    else if (cnt_en) count_in <= count_in + 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Structural rules that must hold every cycle outside reset.
  always @(negedge clock) begin
    if (!reset) begin
      chk("inv_step_cnt_en", int'(step_en), int'(cnt_en));
      chk("inv_load_step", int'(load & step_en), 0);
      chk("inv_ready_busy", int'(result_ready & busy), 0);
      if (!abort) chk("inv_load_clr", int'(load), int'(cnt_clr));
    end
  end

  // Issue one start in the current cycle (cycle 0) and observe until result_ready.
  task automatic run_op(input logic m, input logic d, input logic dz,
                        output int load_c, output int steps, output int first_s,
                        output int last_s, output int ready_c,
                        output logic exc, output logic opd);
    load_c = -1; steps = 0; first_s = -1; last_s = -1; ready_c = -1;
    exc = 1'b0; opd = 1'b0;
    ctrl_mult = m; ctrl_div = d; div_zero = dz;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 1) begin ctrl_mult = 1'b0; ctrl_div = 1'b0; end
      if (load && load_c < 0) load_c = k;
      if (step_en) begin
        steps++;
        if (first_s < 0) first_s = k;
        last_s = k;
      end
      if (result_ready) begin
        ready_c = k; exc = exception; opd = op_is_div;
        break;
      end
    end
    div_zero = 1'b0;
  endtask

  typedef struct packed {
    logic m; logic d; logic dz;
    int load_c; int steps; int first_s; int last_s; int ready_c;
    logic exc; logic opd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int   lc, st, fs, ls, rc, nloads, nready;
    logic ex, od;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1, 16, 2, 17, 18, 1'b0, 1'b0};  // multiply
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1, 32, 2, 33, 34, 1'b0, 1'b1};  // divide
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1,  0, -1, -1, 2, 1'b1, 1'b1};  // divide by zero
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1, 16, 2, 17, 18, 1'b0, 1'b0};  // mult ignores div_zero, clears exc
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1, 16, 2, 17, 18, 1'b0, 1'b0};  // both: multiply wins
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1, 32, 2, 33, 34, 1'b0, 1'b1};  // divide again

    reset = 1'b1; ctrl_mult = 1'b0; ctrl_div = 1'b0; div_zero = 1'b0; abort = 1'b0;
    repeat (3) tick();
    chk("rst_cnt_clr", int'(cnt_clr), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(result_ready), 0);
    chk("rst_opdiv", int'(op_is_div), 0);
    reset = 1'b0;
    tick();
    chk("idle_cnt_clr", int'(cnt_clr), 0);
    chk("idle_load", int'(load), 0);
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].m, vecs[i].d, vecs[i].dz, lc, st, fs, ls, rc, ex, od);
      chk($sformatf("v%0d_load_cycle", i), lc, vecs[i].load_c);
      chk($sformatf("v%0d_steps", i), st, vecs[i].steps);
      chk($sformatf("v%0d_first_step", i), fs, vecs[i].first_s);
      chk($sformatf("v%0d_last_step", i), ls, vecs[i].last_s);
      chk($sformatf("v%0d_ready_cycle", i), rc, vecs[i].ready_c);
      chk($sformatf("v%0d_exception", i), int'(ex), int'(vecs[i].exc));
      chk($sformatf("v%0d_op_is_div", i), int'(od), int'(vecs[i].opd));
      repeat (2) tick();
      chk($sformatf("v%0d_hold_exc", i), int'(exception), int'(vecs[i].exc));
      chk($sformatf("v%0d_hold_opdiv", i), int'(op_is_div), int'(vecs[i].opd));
      chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
    end

    // Divide request during RUN of a multiply is ignored.
    nloads = 0; rc = -1; od = 1'b1;
    ctrl_mult = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k == 1) ctrl_mult = 1'b0;
      if (k == 5) ctrl_div = 1'b1;
      if (k == 6) ctrl_div = 1'b0;
      if (load) nloads++;
      if (result_ready && rc < 0) begin rc = k; od = op_is_div; end
    end
    chk("ign_div_ready", rc, 18);
    chk("ign_div_opdiv", int'(od), 0);
    chk("ign_div_loads", nloads, 1);

    // Back-to-back divide issued in the DONE cycle.
    run_op(1'b0, 1'b1, 1'b0, lc, st, fs, ls, rc, ex, od);
    chk("b2b_first_ready", rc, 34);
    run_op(1'b0, 1'b1, 1'b0, lc, st, fs, ls, rc, ex, od);
    chk("b2b_load", lc, 1);
    chk("b2b_ready", rc, 34);
    chk("b2b_steps", st, 32);
    repeat (2) tick();

    // Reset held three cycles in the middle of a multiply.
    ctrl_mult = 1'b1;
    tick();
    ctrl_mult = 1'b0;
    repeat (5) tick();
    chk("mid_pre_step", int'(step_en), 1);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_cnt_clr", int'(cnt_clr), 1);
      chk("mid_rst_step", int'(step_en), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ready", int'(result_ready), 0);
      chk("mid_rst_opdiv", int'(op_is_div), 0);
      tick();
    end
    reset = 1'b0;
    nready = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (result_ready || busy) nready++;
    end
    chk("mid_rst_no_result", nready, 0);
    run_op(1'b1, 1'b0, 1'b0, lc, st, fs, ls, rc, ex, od);
    chk("mid_rst_after_ready", rc, 18);
    repeat (2) tick();

`ifdef MULTDIV_SEQ_ABORT_EN
    // Abort in the fifth RUN cycle of a multiply.
    ctrl_mult = 1'b1;
    tick();
    ctrl_mult = 1'b0;
    repeat (5) tick();
    chk("abort_in_run", int'(step_en), 1);
    abort = 1'b1;
    #1;
    chk("abort_cnt_clr", int'(cnt_clr), 1);
    tick();
    abort = 1'b0;
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_idle_step", int'(step_en), 0);
    nready = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (result_ready) nready++;
    end
    chk("abort_no_result", nready, 0);
    run_op(1'b1, 1'b0, 1'b0, lc, st, fs, ls, rc, ex, od);
    chk("abort_after_ready", rc, 18);
    chk("abort_after_steps", st, 16);
    repeat (2) tick();

    // Abort beats a divide-by-zero skip in LOAD.
    ctrl_div = 1'b1; div_zero = 1'b1;
    tick();
    ctrl_div = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0; div_zero = 1'b0;
    nready = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (result_ready) nready++;
    end
    chk("abort_dz_no_result", nready, 0);
    chk("abort_dz_exc", int'(exception), 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
